instruction_encoder: RTL and testbench

//  Inverse of the decode-side immediate extraction: packs opcode, register, funct and 32-bit immediate

---
 rtl/instruction_encoder_pkg.sv | 45 ++++
 rtl/instruction_encoder_instr_pack.sv | 58 +++++
 rtl/instruction_encoder.sv | 134 +++++++++++++
 tb/tb_instruction_encoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoder definitions: opcodes, encoder FSM states, NOP word,
// request struct and immediate range helpers.
package instruction_encoder_pkg;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

   localparam logic [31:0] ENC_NOP = 32'h0000_0013;

   typedef enum logic {
      ENC_ST_IDLE  = 1'b0,
      ENC_ST_LI_LO = 1'b1
   } enc_state_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_req_t;

   // True when v equals the sign extension of its low N bits.
   function automatic logic fits_s12(input logic [31:0] v);
      return v[31:11] == {21{v[11]}};
   endfunction

   function automatic logic fits_s13(input logic [31:0] v);
      return v[31:12] == {20{v[12]}};
   endfunction

   function automatic logic fits_s21(input logic [31:0] v);
      return v[31:20] == {12{v[20]}};
   endfunction

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// Combinational RV32I field packer: request fields -> {instruction word, range error}.
module instr_pack
   import instruction_encoder_pkg::*;
(
   input  enc_req_t    req,
   output logic [31:0] word,
   output logic        err
);

   logic is_shift;
   assign is_shift = (req.funct3 == 3'b001) || (req.funct3 == 3'b101);

   always_comb begin
      word = ENC_NOP;
      err  = 1'b1;
      case (req.opcode)
         OPCODE_OP_IMM: begin
            if (is_shift) begin
               word = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
               err  = |req.imm[31:5];
            end else begin
               word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
               err  = ~fits_s12(req.imm);
            end
         end
         OPCODE_LOAD, OPCODE_JALR: begin
            word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            err  = ~fits_s12(req.imm);
         end
         OPCODE_OP: begin
            word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            err  = 1'b0;
         end
         OPCODE_STORE: begin
            word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            err  = ~fits_s12(req.imm);
         end
         OPCODE_BRANCH: begin
            word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                    req.imm[4:1], req.imm[11], req.opcode};
            err  = req.imm[0] | ~fits_s13(req.imm);
         end
         OPCODE_LUI, OPCODE_AUIPC: begin
            word = {req.imm[31:12], req.rd, req.opcode};
            err  = |req.imm[11:0];
         end
         OPCODE_JAL: begin
            word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
            err  = req.imm[0] | ~fits_s21(req.imm);
         end
         default: begin
            word = ENC_NOP;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder with valid/ready on both sides and one output register.
// Optional pseudo LI expansion (ADDI or LUI+ADDI) enabled by defining ENC_PSEUDO_LI_EN.
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   input  logic             in_pseudo_li,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic             out_last,
   output logic [CNT_W-1:0] instr_count
);

   enc_state_e  state, state_nxt;
   enc_req_t    in_req, req;
   logic [31:0] pack_word;
   logic        pack_err;
   logic        can_load, accept, load, last_nxt;

   assign can_load = ~out_valid | out_ready;
   assign in_ready = (state == ENC_ST_IDLE) & can_load;
   assign accept   = in_valid & in_ready;

   assign in_req = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                     funct3: in_funct3, funct7: in_funct7, imm: in_imm};

`ifdef ENC_PSEUDO_LI_EN
   logic [4:0]  li_rd;
   logic [11:0] li_lo;
   logic [19:0] li_hi;

   // Round the upper part up when the low 12 bits will be sign-extended negative.
   assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
`else
   logic unused_li;
   assign unused_li = in_pseudo_li;
`endif

   always_comb begin
      state_nxt = state;
      req       = in_req;
      load      = 1'b0;
      last_nxt  = 1'b1;
      case (state)
         ENC_ST_IDLE: begin
            if (accept) begin
               load = 1'b1;
`ifdef ENC_PSEUDO_LI_EN
               if (in_pseudo_li) begin
                  if (fits_s12(in_imm)) begin
                     req = '{opcode: OPCODE_OP_IMM, rd: in_rd, rs1: 5'd0, rs2: 5'd0,
                             funct3: 3'b000, funct7: 7'd0, imm: in_imm};
                  end else begin
                     req = '{opcode: OPCODE_LUI, rd: in_rd, rs1: 5'd0, rs2: 5'd0,
                             funct3: 3'b000, funct7: 7'd0, imm: {li_hi, 12'h000}};
                     last_nxt  = 1'b0;
                     state_nxt = ENC_ST_LI_LO;
                  end
               end
`endif
            end
         end
`ifdef ENC_PSEUDO_LI_EN
         ENC_ST_LI_LO: begin
            if (can_load) begin
               load      = 1'b1;
               req       = '{opcode: OPCODE_OP_IMM, rd: li_rd, rs1: li_rd, rs2: 5'd0,
                             funct3: 3'b000, funct7: 7'd0, imm: {{20{li_lo[11]}}, li_lo}};
               state_nxt = ENC_ST_IDLE;
            end
         end
`endif
         default: state_nxt = ENC_ST_IDLE;
      endcase
   end

   instr_pack u_pack (
      .req  (req),
      .word (pack_word),
      .err  (pack_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ENC_ST_IDLE;
      else        state <= state_nxt;
   end

`ifdef ENC_PSEUDO_LI_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         li_rd <= 5'd0;
         li_lo <= 12'd0;
      end else if (state == ENC_ST_IDLE && state_nxt == ENC_ST_LI_LO) begin
         li_rd <= in_rd;
         li_lo <= in_imm[11:0];
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_instr   <= 32'd0;
         out_err     <= 1'b0;
         out_last    <= 1'b0;
         instr_count <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_instr <= pack_word;
            out_err   <= pack_err;
            out_last  <= last_nxt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid & out_ready) instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Table-driven bench for instruction_encoder plus hand sequences for stall, LI and reset.
module tb_instruction_encoder;

   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        in_pseudo_li;
   logic        out_valid, out_ready;
   logic [31:0] out_instr;
   logic        out_err, out_last;
   logic [15:0] instr_count;

   int n_cmp = 0;
   int n_bad = 0;

   instruction_encoder #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .in_pseudo_li(in_pseudo_li),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err), .out_last(out_last),
      .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   localparam int NV = 16;
   vec_t vt[NV];

   function automatic vec_t mk(string nm, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                               logic [31:0] imm, logic [31:0] ei, logic ee);
      vec_t v;
      v.name = nm; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
      v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v, logic pli);
      in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm; in_pseudo_li = pli;
   endtask

   task automatic drive_li(logic [4:0] rd, logic [31:0] imm);
      in_opcode = 7'h00; in_rd = rd; in_rs1 = 5'd0; in_rs2 = 5'd0;
      in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = imm; in_pseudo_li = 1'b1;
   endtask

   vec_t va, vb;

   initial begin
      vt[0]  = mk("addi",      7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h0050_0093, 1'b0);
      vt[1]  = mk("sw",        7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020_A423, 1'b0);
      vt[2]  = mk("beq_neg",   7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
      vt[3]  = mk("jal_odd",   7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        32'h0020_00EF, 1'b1);
      vt[4]  = mk("addi_big",  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800,      32'h8000_0093, 1'b1);
      vt[5]  = mk("lui_low",   7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1001,     32'h0000_10B7, 1'b1);
      vt[6]  = mk("add",       7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h0020_81B3, 1'b0);
      vt[7]  = mk("sub",       7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0);
      vt[8]  = mk("srai",      7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3,        32'h4030_D093, 1'b0);
      vt[9]  = mk("slli_32",   7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'd32,       32'h0000_9093, 1'b1);
      vt[10] = mk("bad_op",    7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd0,        32'h0000_0013, 1'b1);
      vt[11] = mk("jal_2048",  7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800,      32'h0010_006F, 1'b0);
      vt[12] = mk("beq_4096",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1000,     32'h8000_0063, 1'b1);
      vt[13] = mk("auipc",     7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F117, 1'b0);
      vt[14] = mk("lw_neg1",   7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'hFFF1_2283, 1'b0);
      vt[15] = mk("beq_odd",   7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,        32'h0000_0063, 1'b1);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(vt[0], 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_err",   {31'd0, out_err}, 32'd0);
      chk("rst_last",  {31'd0, out_last}, 32'd0);
      chk("rst_count", {16'd0, instr_count}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Back-to-back table, out_ready held high: one word per cycle.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vt[i], 1'b0);
         in_valid = 1'b1;
         #1 chk({vt[i].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         chk({vt[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
         chk({vt[i].name, "_instr"}, out_instr, vt[i].exp_instr);
         chk({vt[i].name, "_err"},   {31'd0, out_err}, {31'd0, vt[i].exp_err});
         chk({vt[i].name, "_last"},  {31'd0, out_last}, 32'd1);
      end
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk); #1;
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("table_count", {16'd0, instr_count}, NV);

      // Backpressure: first word held 3 cycles, second request waits.
      va = vt[0]; vb = vt[6];
      @(negedge clk);
      out_ready = 1'b0; drive(va, 1'b0); in_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk) drive(vb, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_instr", out_instr, va.exp_instr);
         chk("bp_count", {16'd0, instr_count}, NV);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("bp_second_instr", out_instr, vb.exp_instr);
      chk("bp_count_1", {16'd0, instr_count}, NV + 1);
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_count_2", {16'd0, instr_count}, NV + 2);

`ifdef ENC_PSEUDO_LI_EN
      // LI needing two words; a normal request waits behind it.
      @(negedge clk);
      drive_li(5'd5, 32'h1234_5FFF); in_valid = 1'b1;
      @(posedge clk); #1;
      chk("li_hi_instr", out_instr, 32'h1234_62B7);
      chk("li_hi_last",  {31'd0, out_last}, 32'd0);
      chk("li_hi_err",   {31'd0, out_err}, 32'd0);
      @(negedge clk) drive(vt[6], 1'b0);
      #1 chk("li_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("li_lo_instr", out_instr, 32'hFFF2_8293);
      chk("li_lo_last",  {31'd0, out_last}, 32'd1);
      chk("li_lo_err",   {31'd0, out_err}, 32'd0);
      @(negedge clk);
      #1 chk("li_after_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("li_next_instr", out_instr, 32'h0020_81B3);
      chk("li_count", {16'd0, instr_count}, NV + 4);
      // Small LI collapses to one ADDI x1,x0,-1.
      @(negedge clk) drive_li(5'd1, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      chk("li_small_instr", out_instr, 32'hFFF0_0093);
      chk("li_small_last",  {31'd0, out_last}, 32'd1);
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk); #1;
      chk("li_small_count", {16'd0, instr_count}, NV + 6);

      // Reset while the LUI beat is stalled: LO beat must never appear.
      @(negedge clk);
      out_ready = 1'b0; drive_li(5'd5, 32'h1234_5FFF); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rli_pre_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rli_async_valid", {31'd0, out_valid}, 32'd0);
      chk("rli_async_count", {16'd0, instr_count}, 32'd0);
      @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("rli_no_lo", {31'd0, out_valid}, 32'd0);
      end
`else
      // Pseudo LI flag ignored: the request packs as a plain ADDI.
      @(negedge clk);
      drive(vt[4], 1'b1); in_valid = 1'b1;
      @(posedge clk); #1;
      chk("noli_instr", out_instr, vt[4].exp_instr);
      chk("noli_err",   {31'd0, out_err}, 32'd1);
      chk("noli_last",  {31'd0, out_last}, 32'd1);
      @(negedge clk) drive(vt[0], 1'b1);
      #1 chk("noli_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("noli_instr2", out_instr, vt[0].exp_instr);

      // Reset while a word is stalled downstream.
      @(negedge clk) begin out_ready = 1'b0; in_valid = 1'b0; end
      @(posedge clk); #1;
      chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_async_count", {16'd0, instr_count}, 32'd0);
      @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("rst_idle_valid", {31'd0, out_valid}, 32'd0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
